// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer
// Sequences a SLICES*Width-bit three-operand add through one shared Width-bit
// 3-input adder slice, LSB slice first. It supports a full carry chain or
// independent SIMD slices. It also accumulates the sum of all slice carry-outs.
module alu_slice_sequencer #(
  parameter int Width  = 8,
  parameter int SLICES = 4,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICES*Width-1:0]   W_in,
  input  logic [SLICES*Width-1:0]   X_in,
  input  logic [SLICES*Width-1:0]   Y_in,
  input  logic [1:0]                cin_in,
  input  logic                      simd_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICES*Width-1:0]   S_out,
  output logic [1:0]                cout_out,
  output logic [CNT_W-1:0]          carry_count,
  output logic [Width-1:0]          alu_W,
  output logic [Width-1:0]          alu_X,
  output logic [Width-1:0]          alu_Y,
  output logic [1:0]                alu_CIN,
  input  logic [Width-1:0]          alu_S,
  input  logic [1:0]                alu_COUT
);

  localparam int OP_W  = SLICES * Width;
  localparam int IDX_W = $clog2(SLICES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   w_q, x_q, y_q;
  logic [1:0]        cin_q;
  logic              simd_q;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        carry_reg;
  logic              accept;
  logic              last_slice;

  assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == IDX_W'(SLICES - 1));
  assign out_valid  = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode: a DONE handshake may chain directly into a new RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice operand mux to the shared ALU; quiet (all zero) outside RUN
  always_comb begin
    alu_W   = '0;
    alu_X   = '0;
    alu_Y   = '0;
    alu_CIN = '0;
    if (state == RUN) begin
      alu_W   = w_q[idx*Width +: Width];
      alu_X   = x_q[idx*Width +: Width];
      alu_Y   = y_q[idx*Width +: Width];
      alu_CIN = (simd_q || (idx == '0)) ? cin_q : carry_reg;
    end
  end

  // Operand capture on accept and per-slice result/carry writeback during RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= '0;
      simd_q      <= 1'b0;
      idx         <= '0;
      carry_reg   <= '0;
      S_out       <= '0;
      cout_out    <= '0;
      carry_count <= '0;
    end else if (accept) begin
      w_q         <= W_in;
      x_q         <= X_in;
      y_q         <= Y_in;
      cin_q       <= cin_in;
      simd_q      <= simd_mode;
      idx         <= '0;
      carry_reg   <= '0;
      S_out       <= '0;
      carry_count <= '0;
    end else if (state == RUN) begin
      S_out[idx*Width +: Width] <= alu_S;
      carry_reg                 <= alu_COUT;
      carry_count               <= carry_count + CNT_W'(alu_COUT);
      idx                       <= idx + 1'b1;
      if (last_slice) cout_out <= alu_COUT;
    end
  end

endmodule
